// File: rtl/control_sequencer_pkg.sv
// Shared opcode map, state encoding and control-word layout for the control sequencer.
package control_sequencer_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned STATE_W = 3;

  // Sequencer states; dense binary encoding.
  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_SETTLE = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  // Opcode map as decoded by the instruction register.
  localparam logic [OP_W-1:0] OP_NOP = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OP_W-1:0] OP_AND = 4'b0011;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0100;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0101;
  localparam logic [OP_W-1:0] OP_NOT = 4'b0110;
  localparam logic [OP_W-1:0] OP_SHL = 4'b0111;
  localparam logic [OP_W-1:0] OP_LD  = 4'b1000;
  localparam logic [OP_W-1:0] OP_ST  = 4'b1001;
  localparam logic [OP_W-1:0] OP_RSV = 4'b1010;
  localparam logic [OP_W-1:0] OP_SHR = 4'b1011;
  localparam logic [OP_W-1:0] OP_INC = 4'b1100;
  localparam logic [OP_W-1:0] OP_BRZ = 4'b1101;
  localparam logic [OP_W-1:0] OP_JMP = 4'b1110;
  localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

  // Control word driven onto the datapath each cycle.
  typedef struct packed {
    logic            il;
    logic            pi;
    logic            pl;
    logic            rw;
    logic [OP_W-1:0] fs;
    logic            md;
    logic            mem_req;
    logic            mw;
    logic            halted;
  } ctrl_t;

  // Opcodes that write an ALU result back to the register file.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return ((op >= OP_ADD) && (op <= OP_SHL)) || (op == OP_SHR) || (op == OP_INC);
  endfunction

  // Opcodes that go through the data-memory handshake.
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: FETCH / SETTLE / DECODE / EXEC|MEM, plus absorbing HALT.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            mem_ack,
  output logic            IL,
  output logic            PI,
  output logic            PL,
  output logic            RW,
  output logic [OP_W-1:0] FS,
  output logic            MD,
  output logic            mem_req,
  output logic            MW,
  output logic            halted
);

  state_e          state_q;
  state_e          state_d;
  logic [OP_W-1:0] op_q;
  ctrl_t           ctrl;

  // State register; reset lands in FETCH so the first edge after release loads an instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Opcode latch; captured only in DECODE so later opcode changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q <= OP_NOP;
    end else if (state_q == ST_DECODE) begin
      op_q <= opcode;
    end
  end

  // Next-state logic; DECODE classifies the opcode being latched this cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_DECODE;
      ST_DECODE: begin
        if (is_mem_op(opcode)) begin
          state_d = ST_MEM;
        end else if (opcode == OP_HLT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC:   state_d = ST_FETCH;
      ST_MEM: begin
        if (mem_ack) begin
          state_d = ST_FETCH;
        end
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Output decode; everything is forced low while reset is held, including mid-MEM.
  always_comb begin
    ctrl = '0;
    if (reset) begin
      case (state_q)
        ST_FETCH: ctrl.il = 1'b1;
        ST_EXEC: begin
          if (op_q != OP_RSV) begin
            ctrl.fs = op_q;
          end
          if (is_alu_op(op_q)) begin
            ctrl.rw = 1'b1;
            ctrl.pi = 1'b1;
          end else if (op_q == OP_BRZ) begin
            ctrl.pl = zero;
            ctrl.pi = !zero;
          end else if (op_q == OP_JMP) begin
            ctrl.pl = 1'b1;
          end else begin
            // NOP and the reserved opcode just advance the PC.
            ctrl.pi = 1'b1;
          end
        end
        ST_MEM: begin
          ctrl.mem_req = 1'b1;
          ctrl.mw      = (op_q == OP_ST);
          if (mem_ack) begin
            ctrl.pi = 1'b1;
            ctrl.rw = (op_q == OP_LD);
            ctrl.md = (op_q == OP_LD);
          end
        end
        ST_HALT: ctrl.halted = 1'b1;
        default: ctrl = '0;
      endcase
    end
  end

  // Port fan-out of the control word.
  assign IL      = ctrl.il;
  assign PI      = ctrl.pi;
  assign PL      = ctrl.pl;
  assign RW      = ctrl.rw;
  assign FS      = ctrl.fs;
  assign MD      = ctrl.md;
  assign mem_req = ctrl.mem_req;
  assign MW      = ctrl.mw;
  assign halted  = ctrl.halted;

endmodule
